// File: rtl/return_address_stack_if.sv
// ----------------------------------------------------------------------------
// return_address_stack_if
//
// Purpose: groups the controller-facing signals of the return address stack.
//
// Signals:
//   push_stack    controller -> stack  push request (JSB)
//   pop_stack     controller -> stack  pop request (RET)
//   push_pc       controller -> stack  PC of the JSB being executed
//   clear_err     controller -> stack  clear both sticky error flags
//   top_out       stack -> controller  current top-of-stack entry (0 when empty)
//   empty / full  stack -> controller  occupancy status
//   count         stack -> controller  occupancy, 0..DEPTH
//   overflow_err  stack -> controller  sticky, push while full
//   underflow_err stack -> controller  sticky, pop while empty
//
// Modports: master = controller side, slave = stack side.
// ----------------------------------------------------------------------------
interface return_address_stack_if #(
  parameter int ADDR_W = 12,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = $clog2(DEPTH) + 1
);
  logic              push_stack;
  logic              pop_stack;
  logic [ADDR_W-1:0] push_pc;
  logic              clear_err;
  logic [ADDR_W-1:0] top_out;
  logic              empty;
  logic              full;
  logic [CNT_W-1:0]  count;
  logic              overflow_err;
  logic              underflow_err;

  modport master (
    output push_stack, pop_stack, push_pc, clear_err,
    input  top_out, empty, full, count, overflow_err, underflow_err
  );

  modport slave (
    input  push_stack, pop_stack, push_pc, clear_err,
    output top_out, empty, full, count, overflow_err, underflow_err
  );
endinterface

// File: rtl/return_address_stack.sv
// ----------------------------------------------------------------------------
// return_address_stack
//
// Purpose: circular LIFO of return addresses for JSB/RET. A push stores
// push_pc+1 (wrapping at ADDR_W bits); a pop exposes the popped entry on
// top_out during the same cycle so the PC can load it on that edge.
// When the stack is full, a push overwrites the oldest entry.
//
// Ports:
//   clk  system clock, rising edge
//   rst  asynchronous active-high reset (pointer, count, error flags)
//   bus  return_address_stack_if.slave: push/pop strobes, push_pc,
//        clear_err in; top_out, empty, full, count, sticky errors out
// ----------------------------------------------------------------------------
module return_address_stack #(
  parameter int ADDR_W = 12,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  return_address_stack_if.slave  bus
);

  localparam int PTR_W = $clog2(DEPTH);

  // Storage: no reset needed, reads are masked while empty.
  logic [ADDR_W-1:0] mem_q [DEPTH];

  logic [PTR_W-1:0] wp_q, wp_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_err_q, overflow_err_d;
  logic             underflow_err_q, underflow_err_d;

  logic              mem_we;
  logic [PTR_W-1:0]  mem_waddr;
  logic [ADDR_W-1:0] mem_wdata;

  logic [PTR_W-1:0] top_idx;
  logic             is_empty;
  logic             is_full;
  logic             set_ovf;
  logic             set_unf;

  // DEPTH is a power of two, so pointer arithmetic wraps for free.
  assign top_idx  = wp_q - PTR_W'(1);
  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == CNT_W'(DEPTH));

  always_comb begin
    wp_d      = wp_q;
    count_d   = count_q;
    mem_we    = 1'b0;
    mem_waddr = wp_q;
    mem_wdata = bus.push_pc + ADDR_W'(1);
    set_ovf   = 1'b0;
    set_unf   = 1'b0;

    if (bus.push_stack && bus.pop_stack) begin
      if (is_empty) begin
        // Nothing to replace: behaves as a plain push, but the pop half
        // still counts as an underflow.
        mem_we  = 1'b1;
        wp_d    = wp_q + PTR_W'(1);
        count_d = CNT_W'(1);
        set_unf = 1'b1;
      end else begin
        // Return-then-call: overwrite the top in place, occupancy unchanged.
        mem_we    = 1'b1;
        mem_waddr = top_idx;
      end
    end else if (bus.push_stack) begin
      mem_we = 1'b1;
      wp_d   = wp_q + PTR_W'(1);
      if (is_full) begin
        // Oldest entry is overwritten; count saturates.
        set_ovf = 1'b1;
      end else begin
        count_d = count_q + CNT_W'(1);
      end
    end else if (bus.pop_stack) begin
      if (is_empty) begin
        set_unf = 1'b1;
      end else begin
        wp_d    = top_idx;
        count_d = count_q - CNT_W'(1);
      end
    end

    // Clearing is applied first so a same-cycle error still wins.
    overflow_err_d  = bus.clear_err ? 1'b0 : overflow_err_q;
    underflow_err_d = bus.clear_err ? 1'b0 : underflow_err_q;
    if (set_ovf) overflow_err_d  = 1'b1;
    if (set_unf) underflow_err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp_q            <= '0;
      count_q         <= '0;
      overflow_err_q  <= 1'b0;
      underflow_err_q <= 1'b0;
    end else begin
      wp_q            <= wp_d;
      count_q         <= count_d;
      overflow_err_q  <= overflow_err_d;
      underflow_err_q <= underflow_err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  // Read-before-write: top_out reflects state before this cycle's edge.
  assign bus.top_out       = is_empty ? '0 : mem_q[top_idx];
  assign bus.empty         = is_empty;
  assign bus.full          = is_full;
  assign bus.count         = count_q;
  assign bus.overflow_err  = overflow_err_q;
  assign bus.underflow_err = underflow_err_q;

endmodule

// File: tb/tb_return_address_stack.sv
module tb_return_address_stack;
  localparam int ADDR_W = 12;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = 3;
  localparam int AMASK  = (1 << ADDR_W) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  return_address_stack_if #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();

  return_address_stack #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int    top_pre;
    int    cnt;
    int    emp;
    int    ful;
    int    top_post;
    int    ovf;
    int    unf;
    string tag;
  } exp_t;

  exp_t exp_q[$];

  // Reference model: a plain queue, back = top of stack.
  int stk[$];
  int m_ovf = 0;
  int m_unf = 0;

  int vectors = 0;
  int miscompares = 0;

  function automatic int m_top();
    if (stk.size() == 0) return 0;
    return stk[stk.size()-1];
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic op(input int push, input int pop, input int pc, input int clr, input string tag);
    exp_t e;
    int   so, su, v;
    so = 0;
    su = 0;
    @(negedge clk);
    e.top_pre = m_top();
    v = (pc + 1) & AMASK;
    if (push != 0 && pop != 0) begin
      if (stk.size() == 0) begin
        stk.push_back(v);
        su = 1;
      end else begin
        stk[stk.size()-1] = v;
      end
    end else if (push != 0) begin
      if (stk.size() == DEPTH) begin
        void'(stk.pop_front());
        so = 1;
      end
      stk.push_back(v);
    end else if (pop != 0) begin
      if (stk.size() == 0) su = 1;
      else void'(stk.pop_back());
    end
    if (clr != 0) begin
      m_ovf = 0;
      m_unf = 0;
    end
    if (so != 0) m_ovf = 1;
    if (su != 0) m_unf = 1;
    e.cnt      = stk.size();
    e.emp      = (stk.size() == 0) ? 1 : 0;
    e.ful      = (stk.size() == DEPTH) ? 1 : 0;
    e.top_post = m_top();
    e.ovf      = m_ovf;
    e.unf      = m_unf;
    e.tag      = tag;
    exp_q.push_back(e);
    bus.push_stack = (push != 0);
    bus.pop_stack  = (pop != 0);
    bus.push_pc    = ADDR_W'(pc);
    bus.clear_err  = (clr != 0);
    $display("op %-10s push=%0d pop=%0d pc=0x%03h clr=%0d -> exp top_pre=0x%03h cnt=%0d top=0x%03h ovf=%0d unf=%0d",
             tag, push, pop, pc & AMASK, clr, e.top_pre, e.cnt, e.top_post, e.ovf, e.unf);
  endtask

  task automatic idle(input string tag);
    op(0, 0, 0, 0, tag);
  endtask

  task automatic drain();
    int i;
    i = 0;
    while (exp_q.size() != 0 && i < 50) begin
      @(posedge clk);
      #2;
      i++;
    end
    chk("drain_queue_empty", exp_q.size(), 0);
  endtask

  // Monitor: captures top_out mid-cycle (pre-edge value), then status after the edge.
  initial begin
    exp_t e;
    int   pre;
    forever begin
      @(negedge clk);
      #1;
      pre = int'(bus.top_out);
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk({e.tag, ".top_pre"},  pre,                     e.top_pre);
        chk({e.tag, ".count"},    int'(bus.count),         e.cnt);
        chk({e.tag, ".empty"},    int'(bus.empty),         e.emp);
        chk({e.tag, ".full"},     int'(bus.full),          e.ful);
        chk({e.tag, ".top_post"}, int'(bus.top_out),       e.top_post);
        chk({e.tag, ".ovf"},      int'(bus.overflow_err),  e.ovf);
        chk({e.tag, ".unf"},      int'(bus.underflow_err), e.unf);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    bus.push_stack = 1'b0;
    bus.pop_stack  = 1'b0;
    bus.push_pc    = '0;
    bus.clear_err  = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset.count", int'(bus.count), 0);
    chk("reset.empty", int'(bus.empty), 1);
    chk("reset.full",  int'(bus.full), 0);
    chk("reset.top",   int'(bus.top_out), 0);
    chk("reset.ovf",   int'(bus.overflow_err), 0);
    chk("reset.unf",   int'(bus.underflow_err), 0);

    // Underflow then clear.
    op(0, 1, 0, 0, "pop_empty");
    op(0, 0, 0, 1, "clr");

    // Three pushes, three pops.
    op(1, 0, 'h010, 0, "push010");
    op(1, 0, 'h020, 0, "push020");
    op(1, 0, 'h030, 0, "push030");
    for (int i = 0; i < 3; i++) op(0, 1, 0, 0, "pop3");

    // Overflow: five pushes into a four-deep stack.
    for (int i = 0; i < 5; i++) op(1, 0, 'h100 + i, 0, "push_ovf");
    for (int i = 0; i < 4; i++) op(0, 1, 0, 0, "pop_ovf");
    op(0, 0, 0, 1, "clr");

    // Simultaneous push and pop, non-empty then empty.
    op(1, 0, 'h040, 0, "push040");
    op(1, 0, 'h050, 0, "push050");
    op(1, 1, 'h070, 0, "pushpop");
    op(0, 1, 0, 0, "pop");
    op(0, 1, 0, 0, "pop");
    op(1, 1, 'h070, 0, "pushpop_e");
    op(0, 1, 0, 0, "pop");
    op(0, 0, 0, 1, "clr");

    // Wraparound of the return address.
    op(1, 0, 'hFFF, 0, "pushFFF");
    op(0, 1, 0, 0, "popFFF");

    // Set wins over clear in the same cycle.
    op(0, 1, 0, 1, "clr_vs_unf");
    op(0, 0, 0, 1, "clr");

    // Push and pop together while full: no error.
    for (int i = 0; i < 4; i++) op(1, 0, 'h200 + i, 0, "fill");
    op(1, 1, 'h2AA, 0, "pushpop_f");

    // Asynchronous reset mid-cycle with three entries.
    for (int i = 0; i < 4; i++) op(0, 1, 0, 0, "pop_all");
    op(0, 0, 0, 1, "clr");
    for (int i = 0; i < 3; i++) op(1, 0, 'h300 + i, 0, "push_rst");
    idle("idle");
    drain();
    #1;
    rst = 1'b1;
    #1;
    stk.delete();
    m_ovf = 0;
    m_unf = 0;
    chk("async_rst.count", int'(bus.count), 0);
    chk("async_rst.empty", int'(bus.empty), 1);
    chk("async_rst.full",  int'(bus.full), 0);
    chk("async_rst.top",   int'(bus.top_out), 0);
    @(negedge clk);
    rst = 1'b0;
    op(1, 0, 'h123, 0, "post_rst");
    op(0, 1, 0, 0, "post_rst");

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      int p, q, c, pc;
      p  = int'($urandom_range(0, 1));
      q  = int'($urandom_range(0, 1));
      c  = ($urandom_range(0, 15) == 0) ? 1 : 0;
      pc = int'($urandom_range(0, AMASK));
      op(p, q, pc, c, "rand");
    end
    idle("idle");
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
